serial_mag_comparator: RTL and testbench

//  Bit-serial magnitude comparator: successor to the 1-bit x/y/a comparator cell, generalised to WIDTH-bit

---
 rtl/serial_cmp_pkg.sv | 25 ++
 rtl/bit_cmp_cell.sv | 23 ++
 rtl/serial_mag_comparator.sv | 96 +++++++++
 tb/tb_serial_mag_comparator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states, running-result
// codes and the code-to-flag decoder.
package serial_cmp_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  typedef logic [1:0] cmp_code_t;

  localparam cmp_code_t CMP_EQ = 2'd0;
  localparam cmp_code_t CMP_GT = 2'd1;
  localparam cmp_code_t CMP_LT = 2'd2;

  // Returns {gt, eq, lt}; an unused code decodes to all-zero.
  function automatic logic [2:0] decode_cmp(input cmp_code_t code);
    logic [2:0] flags;
    case (code)
      CMP_EQ:  flags = 3'b010;
      CMP_GT:  flags = 3'b100;
      CMP_LT:  flags = 3'b001;
      default: flags = 3'b000;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/bit_cmp_cell.sv
// One-beat comparator cell: folds a single x/y bit pair into the running result,
// honouring bit order, MSB-first lock-in and the two's complement sign beat.
module bit_cmp_cell
  import serial_cmp_pkg::*;
(
  input  cmp_code_t cur_result,
  input  logic      x,
  input  logic      y,
  input  logic      is_sign_bit,
  input  logic      lsb_first,
  input  logic      locked,
  output cmp_code_t next_result
);

  // On the sign beat a 1 in x means x is negative, so the decision flips.
  always_comb begin
    next_result = cur_result;
    if ((x != y) && (lsb_first || !locked)) begin
      next_result = (x ^ is_sign_bit) ? CMP_GT : CMP_LT;
    end
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial WIDTH-bit magnitude comparator with start/in_valid framing.
// Define CMP_SIGNED_EN for two's complement operands; otherwise unsigned.
module serial_mag_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic in_valid,
  input  logic x,
  input  logic y,
  output logic busy,
  output logic res_valid,
  output logic gt,
  output logic eq,
  output logic lt
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  cmp_code_t        run_q;

  logic             accept;
  logic             last_beat;
  logic             sign_beat;
  logic             locked;
  logic [CNT_W-1:0] beat_idx;
  cmp_code_t        cur_eff;
  cmp_code_t        nxt_result;

  // A start beat always sees a fresh frame: index 0 and a cleared running result.
  assign accept    = in_valid && ((state_q == ST_RUN) || start);
  assign beat_idx  = start ? '0 : cnt_q;
  assign last_beat = accept && (beat_idx == LAST_IDX);
  assign cur_eff   = start ? CMP_EQ : run_q;
  assign locked    = (cur_eff != CMP_EQ);

`ifdef CMP_SIGNED_EN
  assign sign_beat = LSB_FIRST ? (beat_idx == LAST_IDX) : (beat_idx == '0);
`else
  assign sign_beat = 1'b0;
`endif

  bit_cmp_cell u_cell (
    .cur_result  (cur_eff),
    .x           (x),
    .y           (y),
    .is_sign_bit (sign_beat),
    .lsb_first   (LSB_FIRST),
    .locked      (locked),
    .next_result (nxt_result)
  );

  // start outranks frame completion, so a colliding start never yields res_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      run_q     <= CMP_EQ;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (start) begin
        state_q <= ST_RUN;
        busy    <= 1'b1;
        gt      <= 1'b0;
        eq      <= 1'b0;
        lt      <= 1'b0;
        run_q   <= accept ? nxt_result : CMP_EQ;
        cnt_q   <= accept ? CNT_W'(1) : '0;
      end else if (accept) begin
        run_q <= nxt_result;
        if (last_beat) begin
          state_q      <= ST_IDLE;
          busy         <= 1'b0;
          cnt_q        <= '0;
          res_valid    <= 1'b1;
          {gt, eq, lt} <= decode_cmp(nxt_result);
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator (WIDTH=4): one LSB-first and one MSB-first instance,
// table vectors, framing corner cases and random frames against an arithmetic model.
module tb_serial_mag_comparator;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  logic start_s    [2];
  logic in_valid_s [2];
  logic x_s        [2];
  logic y_s        [2];
  logic busy_s     [2];
  logic res_valid_s[2];
  logic gt_s       [2];
  logic eq_s       [2];
  logic lt_s       [2];

  int tests;
  int fails;

  // Index 0: LSB-first instance, index 1: MSB-first instance.
  serial_mag_comparator #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .x(x_s[0]), .y(y_s[0]), .busy(busy_s[0]), .res_valid(res_valid_s[0]),
    .gt(gt_s[0]), .eq(eq_s[0]), .lt(lt_s[0])
  );

  serial_mag_comparator #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .x(x_s[1]), .y(y_s[1]), .busy(busy_s[1]), .res_valid(res_valid_s[1]),
    .gt(gt_s[1]), .eq(eq_s[1]), .lt(lt_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         d;
    logic [3:0] a;
    logic [3:0] b;
    int         gap;
    logic [2:0] exp_u;
    logic [2:0] exp_s;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: plain integer comparison of the two operand words, {gt,eq,lt}.
  function automatic logic [2:0] model(input logic [3:0] a, input logic [3:0] b);
    int va;
    int vb;
`ifdef CMP_SIGNED_EN
    va = int'($signed(a));
    vb = int'($signed(b));
`else
    va = int'({1'b0, a});
    vb = int'({1'b0, b});
`endif
    if (va > vb) return 3'b100;
    if (va < vb) return 3'b001;
    return 3'b010;
  endfunction

  function automatic logic [2:0] flags(input int d);
    return {gt_s[d], eq_s[d], lt_s[d]};
  endfunction

  task automatic idle_inputs(input int d);
    start_s[d]    = 1'b0;
    in_valid_s[d] = 1'b0;
    x_s[d]        = 1'b0;
    y_s[d]        = 1'b0;
  endtask

  // Streams nbeats bits of a/b in the instance's bit order, starting a fresh frame.
  // stray flags any res_valid or non-zero result seen before the final beat.
  task automatic send_beats(input int d, input logic [3:0] a, input logic [3:0] b,
                            input int nbeats, input int gap, output logic stray);
    logic [3:0] av;
    logic [3:0] bv;
    int bi;
    av = a;
    bv = b;
    stray = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bi = (d == 0) ? i : (W - 1 - i);
      @(negedge clk);
      start_s[d]    = (i == 0);
      in_valid_s[d] = 1'b1;
      x_s[d]        = av[bi];
      y_s[d]        = bv[bi];
      @(posedge clk);
      #1;
      if (i < W - 1 && (res_valid_s[d] || flags(d) != 3'b000)) stray = 1'b1;
      if (i < nbeats - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          start_s[d]    = 1'b0;
          in_valid_s[d] = 1'b0;
          x_s[d]        = ~x_s[d];
          y_s[d]        = 1'b0;
          @(posedge clk);
          #1;
          if (res_valid_s[d] || flags(d) != 3'b000) stray = 1'b1;
        end
      end
    end
    @(negedge clk);
    idle_inputs(d);
  endtask

  // Full frame; checks result on the completing edge, then pulse end and hold.
  task automatic full_frame(input string name, input int d, input logic [3:0] a,
                            input logic [3:0] b, input int gap, input logic [2:0] req);
    logic stray;
    logic rv;
    logic [2:0] res;
    logic bsy;
    send_beats(d, a, b, W, gap, stray);
    // send_beats returns at the negedge after the final accepting edge.
    rv  = res_valid_s[d];
    res = flags(d);
    bsy = busy_s[d];
    check({name, " early"}, 32'(stray), 32'd0);
    check({name, " res_valid"}, 32'(rv), 32'd1);
    check({name, " result"}, 32'(res), 32'(req));
    check({name, " busy"}, 32'(bsy), 32'd0);
    @(posedge clk);
    #1;
    check({name, " pulse"}, 32'(res_valid_s[d]), 32'd0);
    check({name, " hold"}, 32'(flags(d)), 32'(req));
  endtask

  initial begin
    logic stray;
    logic [3:0] ra;
    logic [3:0] rb;
    tests = 0;
    fails = 0;
    for (int d = 0; d < 2; d++) idle_inputs(d);

    // Stream words as written MSB..LSB; expected {gt,eq,lt} unsigned / signed.
    vecs[0] = '{0, 4'b1010, 4'b0110, 0, 3'b100, 3'b001};
    vecs[1] = '{1, 4'b0101, 4'b0101, 2, 3'b010, 3'b010};
    vecs[2] = '{1, 4'b0100, 4'b0011, 0, 3'b100, 3'b100};
    vecs[3] = '{0, 4'b1000, 4'b0001, 1, 3'b100, 3'b001};
    vecs[4] = '{1, 4'b1000, 4'b0001, 0, 3'b100, 3'b001};
    vecs[5] = '{0, 4'b0011, 4'b0101, 0, 3'b001, 3'b001};
    vecs[6] = '{1, 4'b1111, 4'b0111, 1, 3'b100, 3'b001};

    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset busy%0d", d), 32'(busy_s[d]), 32'd0);
      check($sformatf("reset flags%0d", d), 32'({res_valid_s[d], flags(d)}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
`ifdef CMP_SIGNED_EN
      full_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].gap, vecs[i].exp_s);
`else
      full_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].gap, vecs[i].exp_u);
`endif
    end

    // in_valid without start while idle must be ignored.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid_s[0] = 1'b1;
      x_s[0] = 1'b1;
      @(posedge clk);
      #1;
      check("idle ignore busy", 32'(busy_s[0]), 32'd0);
      check("idle ignore rv", 32'(res_valid_s[0]), 32'd0);
    end
    @(negedge clk);
    idle_inputs(0);

    // Abort after 2 beats, then a fresh frame.
    send_beats(0, 4'b1111, 4'b0000, 2, 0, stray);
    check("abort partial", 32'(stray), 32'd0);
    check("abort busy", 32'(busy_s[0]), 32'd1);
    full_frame("abort new", 0, 4'b0001, 4'b0010, 0, model(4'b0001, 4'b0010));

    // Start arriving with what would have been the 4th beat of the old frame.
    send_beats(1, 4'b1111, 4'b0000, 3, 0, stray);
    check("collide partial", 32'(stray), 32'd0);
    full_frame("collide new", 1, 4'b0010, 4'b0110, 0, model(4'b0010, 4'b0110));

    // Reset mid-frame: everything drops immediately.
    send_beats(0, 4'b0110, 4'b0101, 3, 0, stray);
    check("rst pre busy", 32'(busy_s[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst mid busy", 32'(busy_s[0]), 32'd0);
    check("rst mid outs", 32'({res_valid_s[0], flags(0)}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    full_frame("after rst", 0, 4'b0110, 4'b0101, 0, model(4'b0110, 4'b0101));

    // Random frames on both instances.
    for (int n = 0; n < 40; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = (n % 5 == 0) ? ra : 4'($urandom_range(0, 15));
      full_frame($sformatf("rand%0d a=%0h b=%0h", n, ra, rb), n % 2, ra, rb,
                 int'($urandom_range(0, 2)), model(ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
